mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port memory between instruction fetch (I) and MEM-stage data access (D).
//  Sits beside the hazard unit and supplies the per-stage stall requests it ORs into stallF / stallM.
//  Non-preemptive FSM with fixed priority: D beats I. Watchdog aborts hung memory transactions.
// PARAMETERS
//  ADDR_W    32   address width (byte address)
//  DATA_W    32   data width; byte-strobe width is DATA_W/8
//  MAX_WAIT  255  cycles in BUSY without mem_ready before abort; must be >=1
// PORTS
//  clk        in   1         clock, rising edge
//  rst        in   1         synchronous, active-high reset
//  i_req      in   1         fetch request; level, held until i_done
//  i_addr     in   ADDR_W    fetch address
//  i_rdata    out  DATA_W    fetch data; valid while i_done=1
//  i_done     out  1         one-cycle completion pulse for I
//  i_stall    out  1         = i_req & ~i_done; combinational
//  d_req      in   1         data request; level, held until d_done
//  d_wen      in   DATA_W/8  byte write strobes; 0 = read
//  d_addr     in   ADDR_W    data address
//  d_wdata    in   DATA_W    store data
//  d_rdata    out  DATA_W    load data; valid while d_done=1
//  d_done     out  1         one-cycle completion pulse for D
//  d_stall    out  1         = d_req & ~d_done; combinational
//  mem_req    out  1         memory request; held until mem_ready
//  mem_wen    out  DATA_W/8  latched strobes
//  mem_addr   out  ADDR_W    latched address
//  mem_wdata  out  DATA_W    latched store data
//  mem_rdata  in   DATA_W    memory read data; sampled when mem_ready=1
//  mem_ready  in   1         memory completes the current access this cycle
//  err        out  1         one-cycle pulse with done when the watchdog aborts
// BEHAVIOUR
//  FSM states: IDLE, D_BUSY, I_BUSY, RESP. Reset: IDLE; every output 0.
//  IDLE: d_req -> latch D fields, go D_BUSY. Else i_req -> latch i_addr (wen=0), go I_BUSY.
//        Else stay in IDLE.
//  Requests are sampled only in IDLE. Each requester is told whether it owns the current
//  response, so a request present in RESP is never granted.
//  D_BUSY / I_BUSY: mem_req=1 from the first BUSY cycle. mem_addr/wen/wdata stay stable.
//    Watchdog counter clears on entry.
//    - mem_ready=1: capture mem_rdata into the owner's rdata register; go RESP.
//    - counter reaches MAX_WAIT without mem_ready: rdata=0, err=1 in RESP; go RESP.
//  RESP: owner's done=1 for exactly this cycle; mem_req=0; next state IDLE.
//  Latency: request seen in IDLE cycle T; mem_req from T+1; mem_ready at T+1+k (k>=0);
//    done at T+2+k. Minimum 3 cycles; back-to-back grants every 3+k cycles.
//  Simultaneous i_req and d_req in IDLE: D is granted. I stalls until it is granted later.
//  No preemption: d_req arriving during I_BUSY waits for I to complete, then wins in IDLE.
//  Stores: d_rdata keeps its previous value. d_done still pulses.
//  rdata registers hold their value until overwritten. They are undefined only before the
//    first completion (reset value 0).
//  mem_ready outside BUSY states: ignored.
//  Reset mid-transaction: the in-flight access is abandoned. mem_req falls on the next edge.
//    No done or err is issued.
//  Watchdog counter is $clog2(MAX_WAIT+1) bits and saturates; it is never compared after exit.
// CONFIGURATION
//  ARB_PERF_EN defined: adds outputs perf_i_grants, perf_d_grants, perf_stall_cycles.
//    Each is 32-bit, clears on rst, and wraps at 2^32.
//    Grants count IDLE->BUSY transitions. Stall counts cycles with i_stall|d_stall.
//  ARB_PERF_EN undefined: those ports and counters are absent.
//    All remaining behaviour is identical, cycle for cycle.
// TESTING
//  1 I fetch only: i_req=1, addr 0x100, mem_ready 2 cycles after mem_req rises, rdata 0xDEADBEEF
//    -> mem_addr=0x100, mem_wen=0, i_done pulse 1 cycle later with i_rdata=0xDEADBEEF.
//  2 Collision: i_req and d_req (read 0x200) rise together -> D served first;
//    i_stall=1 through d_done; I granted in the IDLE after RESP.
//  3 Store: d_wen=4'b0011, addr 0x40, wdata 0x12345678, mem_ready=1 immediately
//    -> mem_wen=0011, mem_wdata=0x12345678, d_done at T+2, d_rdata unchanged.
//  4 Watchdog: MAX_WAIT=4, mem_ready held 0 -> after 4 BUSY cycles:
//    done=1, err=1, rdata=0, mem_req=0.
//  5 Reset mid-access: assert rst during D_BUSY -> next cycle mem_req=0, state IDLE,
//    no done/err; a new request afterwards completes normally.
//  6 ARB_PERF_EN: 3 D and 2 I transactions -> perf_d_grants=3, perf_i_grants=2,
//    perf_stall_cycles equals the cycles the bench measured.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester (I/D) and memory-side signals of the shared memory port arbiter
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  i_req;
  logic [ADDR_W-1:0]     i_addr;
  logic [DATA_W-1:0]     i_rdata;
  logic                  i_done;
  logic                  i_stall;
  logic                  d_req;
  logic [DATA_W/8-1:0]   d_wen;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic [DATA_W-1:0]     d_rdata;
  logic                  d_done;
  logic                  d_stall;
  logic                  mem_req;
  logic [DATA_W/8-1:0]   mem_wen;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;
  logic                  mem_ready;
  logic                  err;
  modport slave (
    input  i_req, i_addr, d_req, d_wen, d_addr, d_wdata, mem_rdata, mem_ready,
    output i_rdata, i_done, i_stall, d_rdata, d_done, d_stall,
           mem_req, mem_wen, mem_addr, mem_wdata, err
  );
  modport master (
    output i_req, i_addr, d_req, d_wen, d_addr, d_wdata, mem_rdata, mem_ready,
    input  i_rdata, i_done, i_stall, d_rdata, d_done, d_stall,
           mem_req, mem_wen, mem_addr, mem_wdata, err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: non-preemptive I/D arbiter for one single-port memory, D has priority, watchdog abort.
// Define ARB_PERF_EN to add the 32-bit grant and stall performance counters.
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 255
)(
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.slave bus
`ifdef ARB_PERF_EN
  ,
  output logic [31:0] perf_i_grants,
  output logic [31:0] perf_d_grants,
  output logic [31:0] perf_stall_cycles
`endif
);
  localparam int SW = DATA_W / 8;
  localparam int CW = $clog2(MAX_WAIT + 1);
  typedef enum logic [1:0] {IDLE, D_BUSY, I_BUSY, RESP} state_e;
  state_e            state_q, state_d;
  logic              own_d_q, err_q;
  logic [CW-1:0]     cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [SW-1:0]     wen_q;
  logic [DATA_W-1:0] wdata_q, i_rdata_q, d_rdata_q;
  logic              busy, grant, timeout, resp, i_done, d_done;
  assign busy    = state_q == D_BUSY || state_q == I_BUSY;
  assign grant   = state_q == IDLE && (bus.d_req || bus.i_req);
  assign timeout = busy && !bus.mem_ready && cnt_q == CW'(MAX_WAIT - 1);
  assign resp    = state_q == RESP;
  assign i_done  = resp && !own_d_q;
  assign d_done  = resp && own_d_q;
  always_ff @(posedge clk)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:           state_d = bus.d_req ? D_BUSY : (bus.i_req ? I_BUSY : IDLE);
      D_BUSY, I_BUSY: state_d = (bus.mem_ready || timeout) ? RESP : state_q;
      default:        state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      own_d_q   <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      addr_q    <= '0;
      wen_q     <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      if (grant) begin
        addr_q  <= bus.d_req ? bus.d_addr : bus.i_addr;
        wen_q   <= bus.d_req ? bus.d_wen : '0;
        wdata_q <= bus.d_req ? bus.d_wdata : wdata_q;
        own_d_q <= bus.d_req;
        err_q   <= 1'b0;
        cnt_q   <= '0;
      end
      if (busy) begin
        cnt_q <= (cnt_q == CW'(MAX_WAIT)) ? cnt_q : cnt_q + 1'b1;
        if (bus.mem_ready || timeout) begin
          err_q <= timeout;
          // stores leave the load-data register untouched, even on abort
          if (!own_d_q) i_rdata_q <= timeout ? '0 : bus.mem_rdata;
          else if (wen_q == '0) d_rdata_q <= timeout ? '0 : bus.mem_rdata;
        end
      end
    end
  end
  always_comb begin
    bus.mem_req   = busy;
    bus.mem_addr  = addr_q;
    bus.mem_wen   = wen_q;
    bus.mem_wdata = wdata_q;
    bus.i_rdata   = i_rdata_q;
    bus.d_rdata   = d_rdata_q;
    bus.i_done    = i_done;
    bus.d_done    = d_done;
    bus.err       = resp && err_q;
    bus.i_stall   = bus.i_req && !i_done;
    bus.d_stall   = bus.d_req && !d_done;
  end
`ifdef ARB_PERF_EN
  always_ff @(posedge clk)
    if (rst) begin
      perf_i_grants     <= '0;
      perf_d_grants     <= '0;
      perf_stall_cycles <= '0;
    end else begin
      perf_i_grants     <= perf_i_grants + 32'(grant && !bus.d_req);
      perf_d_grants     <= perf_d_grants + 32'(grant && bus.d_req);
      perf_stall_cycles <= perf_stall_cycles + 32'((bus.i_req && !i_done) || (bus.d_req && !d_done));
    end
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized transactions checked against a transaction-level timing model.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
`ifdef ARB_PERF_EN
  logic [31:0] perf_i_grants, perf_d_grants, perf_stall_cycles;
`endif
  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef ARB_PERF_EN
    ,
    .perf_i_grants(perf_i_grants),
    .perf_d_grants(perf_d_grants),
    .perf_stall_cycles(perf_stall_cycles)
`endif
  );
  int n_vec = 0;
  int n_err = 0;
  logic [31:0] m_irdata = '0;
  logic [31:0] m_drdata = '0;
  int m_ig = 0;
  int m_dg = 0;
  int m_stall = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic idle_inputs();
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    bus.mem_ready = 1'b0;
    bus.i_addr = '0;
    bus.d_addr = '0;
    bus.d_wen = '0;
    bus.d_wdata = '0;
    bus.mem_rdata = '0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    @(posedge clk); #1;
    chk("rst_mem_req", 64'(bus.mem_req), 64'(0));
    chk("rst_i_done", 64'(bus.i_done), 64'(0));
    chk("rst_d_done", 64'(bus.d_done), 64'(0));
    chk("rst_err", 64'(bus.err), 64'(0));
    chk("rst_mem_addr", 64'(bus.mem_addr), 64'(0));
    chk("rst_mem_wen", 64'(bus.mem_wen), 64'(0));
    chk("rst_i_rdata", 64'(bus.i_rdata), 64'(0));
    chk("rst_d_rdata", 64'(bus.d_rdata), 64'(0));
    rst = 1'b0;
    m_irdata = '0;
    m_drdata = '0;
    m_ig = 0;
    m_dg = 0;
    m_stall = 0;
    @(posedge clk); #1;
  endtask
  // Entered and left at posedge+1 with the arbiter idle; cycle 0 is the first cycle requests may appear.
  task automatic episode(input bit hi, input int ia, input int ki, input logic [31:0] iaddr,
                         input bit hd, input int da, input int kd, input logic [31:0] daddr,
                         input logic [3:0] dwen, input logic [31:0] dwdata);
    bit e_busy[32], e_own[32], e_rdy[32], e_idone[32], e_ddone[32], e_err[32], e_chk[32];
    logic [31:0] e_addr[32], e_rdv[32], e_rdx[32];
    logic [3:0] e_wen[32];
    int t = 0;
    int i_end = -1;
    int d_end = -1;
    bit ip = hi;
    bit dp = hd;
    bit exp_is, exp_ds;
    for (int c = 0; c < 32; c++) begin
      e_busy[c] = 0; e_own[c] = 0; e_rdy[c] = 0; e_idone[c] = 0; e_ddone[c] = 0;
      e_err[c] = 0; e_chk[c] = 0; e_addr[c] = '0; e_rdv[c] = '0; e_rdx[c] = '0; e_wen[c] = '0;
    end
    while (ip || dp) begin
      bit g, ab;
      int k, kk, rsp;
      logic [31:0] rdv;
      if (dp && da <= t) g = 1;
      else if (ip && ia <= t) g = 0;
      else begin
        t++;
        continue;
      end
      k = g ? kd : ki;
      ab = k >= MW;
      kk = ab ? MW - 1 : k;
      rdv = $urandom;
      for (int c = t + 1; c <= t + 1 + kk; c++) begin
        e_busy[c] = 1;
        e_own[c] = g;
        e_addr[c] = g ? daddr : iaddr;
        e_wen[c] = g ? dwen : 4'h0;
      end
      if (!ab) begin
        e_rdy[t + 1 + kk] = 1;
        e_rdv[t + 1 + kk] = rdv;
      end
      rsp = t + 2 + kk;
      e_err[rsp] = ab;
      if (g) begin
        if (dwen == 4'h0) m_drdata = ab ? 32'h0 : rdv;
        e_ddone[rsp] = 1;
        e_chk[rsp] = !(ab && dwen != 4'h0);
        e_rdx[rsp] = m_drdata;
        d_end = rsp;
        dp = 0;
        m_dg++;
      end else begin
        m_irdata = ab ? 32'h0 : rdv;
        e_idone[rsp] = 1;
        e_chk[rsp] = 1;
        e_rdx[rsp] = m_irdata;
        i_end = rsp;
        ip = 0;
        m_ig++;
      end
      t = rsp + 1;
    end
    for (int c = 0; c <= t; c++) begin
      bus.i_req = hi && c >= ia && c <= i_end;
      bus.d_req = hd && c >= da && c <= d_end;
      bus.i_addr = iaddr;
      bus.d_addr = daddr;
      bus.d_wen = dwen;
      bus.d_wdata = dwdata;
      bus.mem_ready = e_busy[c] ? e_rdy[c] : 1'($urandom);
      bus.mem_rdata = e_rdy[c] ? e_rdv[c] : $urandom;
      #1;
      exp_is = bus.i_req && !e_idone[c];
      exp_ds = bus.d_req && !e_ddone[c];
      m_stall += int'(exp_is || exp_ds);
      chk("mem_req", 64'(bus.mem_req), 64'(e_busy[c]));
      chk("i_done", 64'(bus.i_done), 64'(e_idone[c]));
      chk("d_done", 64'(bus.d_done), 64'(e_ddone[c]));
      chk("err", 64'(bus.err), 64'(e_err[c]));
      chk("i_stall", 64'(bus.i_stall), 64'(exp_is));
      chk("d_stall", 64'(bus.d_stall), 64'(exp_ds));
      if (e_busy[c]) begin
        chk("mem_addr", 64'(bus.mem_addr), 64'(e_addr[c]));
        chk("mem_wen", 64'(bus.mem_wen), 64'(e_wen[c]));
        if (e_own[c]) chk("mem_wdata", 64'(bus.mem_wdata), 64'(dwdata));
      end
      if (e_idone[c]) chk("i_rdata", 64'(bus.i_rdata), 64'(e_rdx[c]));
      if (e_ddone[c] && e_chk[c]) chk("d_rdata", 64'(bus.d_rdata), 64'(e_rdx[c]));
      @(posedge clk); #1;
    end
    bus.mem_ready = 1'b0;
  endtask
  initial begin
    idle_inputs();
    @(posedge clk); #1;
    do_reset();
    episode(1, 0, 2, 32'h100, 0, 0, 0, 32'h0, 4'h0, 32'h0);
    episode(1, 0, 1, 32'h104, 1, 0, 2, 32'h200, 4'h0, 32'h0);
    episode(0, 0, 0, 32'h0, 1, 0, 0, 32'h40, 4'b0011, 32'h12345678);
    episode(1, 0, 9, 32'h108, 0, 0, 0, 32'h0, 4'h0, 32'h0);
    episode(0, 0, 0, 32'h0, 1, 0, 9, 32'h204, 4'h0, 32'h0);
    episode(1, 0, 3, 32'h10c, 1, 2, 1, 32'h208, 4'h0, 32'h0);
    episode(1, 3, 0, 32'h110, 1, 0, 1, 32'h20c, 4'hf, 32'hcafef00d);
    // abandon a D access mid-flight; nothing may complete
    bus.d_req = 1'b1;
    bus.d_addr = 32'h300;
    bus.d_wen = '0;
    @(posedge clk); #1;
    chk("mid_mem_req", 64'(bus.mem_req), 64'(1));
    @(posedge clk); #1;
    rst = 1'b1;
    bus.d_req = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_mem_req", 64'(bus.mem_req), 64'(0));
    chk("mid_rst_d_done", 64'(bus.d_done), 64'(0));
    chk("mid_rst_err", 64'(bus.err), 64'(0));
    rst = 1'b0;
    m_irdata = '0;
    m_drdata = '0;
    m_ig = 0;
    m_dg = 0;
    m_stall = 0;
    @(posedge clk); #1;
    chk("post_rst_mem_req", 64'(bus.mem_req), 64'(0));
    chk("post_rst_d_done", 64'(bus.d_done), 64'(0));
    chk("post_rst_d_rdata", 64'(bus.d_rdata), 64'(0));
    episode(0, 0, 0, 32'h0, 1, 0, 1, 32'h304, 4'h0, 32'h0);
    for (int n = 0; n < 200; n++) begin
      bit hi, hd;
      hi = 1'($urandom);
      hd = 1'($urandom);
      if (!hi && !hd) hi = 1;
      episode(hi, $urandom_range(0, 4), $urandom_range(0, 5), $urandom,
              hd, $urandom_range(0, 4), $urandom_range(0, 5), $urandom,
              $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15)), $urandom);
    end
`ifdef ARB_PERF_EN
    chk("perf_i_grants", 64'(perf_i_grants), 64'(m_ig));
    chk("perf_d_grants", 64'(perf_d_grants), 64'(m_dg));
    chk("perf_stall_cycles", 64'(perf_stall_cycles), 64'(m_stall));
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
